ro_collector: RTL and testbench

Receive-side counterpart of the readout bus. Eight readout blocks take turns driving the shared 2-bit tri-state bus, one slot per channel. This block sits at the bus's far end and runs on `clk_ext`. Starting at a frame-sync pulse, it samples the bus once per slot, packs the N_CH 2-bit channel values into one frame word, and buffers completed words in a small FIFO behind a valid/ready output handshake.

---
 rtl/ro_pkg.sv | 21 ++
 rtl/ro_fifo.sv | 65 ++++++
 rtl/ro_collector.sv | 173 +++++++++++++++++
 tb/tb_ro_collector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ro_pkg
//  Purpose  : Shared defaults, tag width and state type for the readout
//             bus receive side.
//  Revision : 1.0  initial release
// ============================================================================
package ro_pkg;

    localparam int N_CH_DEF       = 8;
    localparam int SLOT_CYC_DEF   = 16;
    localparam int SAMPLE_OFS_DEF = 8;
    localparam int FRAME_ID_W     = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } ro_col_state_t;

endpackage
`default_nettype wire

// File: rtl/ro_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ro_fifo
//  Purpose  : Small synchronous FIFO; a push into a full FIFO succeeds when
//             a pop happens in the same cycle. Head is read combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module ro_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk_ext,
    input  logic             rstb,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             w_do_pop;
    logic             w_do_push;

    always_comb begin
        empty     = (wr_q == rd_q);
        full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
        pop_data  = mem_q[rd_q[AW-1:0]];

        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (w_do_push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ro_collector.sv
`default_nettype none
// ============================================================================
//  Module   : ro_collector
//  Purpose  : Samples the shared 2-bit readout bus once per slot after a
//             frame sync, packs N_CH values per word and buffers the words.
//  Options  : RO_COLLECT_FRAMECNT_EN adds a frame_id tag per buffered word.
//  Revision : 1.0  initial release
// ============================================================================
module ro_collector
    import ro_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int SLOT_CYC   = SLOT_CYC_DEF,
    parameter int SAMPLE_OFS = SAMPLE_OFS_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_ext,
    input  logic                  rstb,
    input  logic                  frame_sync,
    input  logic [1:0]            bus_in,
    output logic [2*N_CH-1:0]     word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  busy,
    output logic                  frame_err,
`ifdef RO_COLLECT_FRAMECNT_EN
    output logic [FRAME_ID_W-1:0] frame_id,
`endif
    output logic                  overflow
);

    localparam int CYC_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int SLOT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WW     = 2 * N_CH;
`ifdef RO_COLLECT_FRAMECNT_EN
    localparam int FW     = WW + FRAME_ID_W;
`else
    localparam int FW     = WW;
`endif

    ro_col_state_t     state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [WW-1:0]     shadow_q, shadow_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;

    logic              w_active;
    logic [SLOT_W-1:0] w_slot;
    logic [CYC_W-1:0]  w_cyc;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FW-1:0]     w_fifo_din;
    logic [FW-1:0]     w_fifo_dout;

`ifdef RO_COLLECT_FRAMECNT_EN
    logic [FRAME_ID_W-1:0] fcnt_q, fcnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cyc_d       = cyc_q;
        shadow_d    = shadow_q;
        w_push      = 1'b0;
        frame_err_d = frame_sync && (state_q == COLLECT);

        // A sync cycle is itself slot 0 / cycle 0, so counters restart here.
        w_active = frame_sync || (state_q == COLLECT);
        w_slot   = frame_sync ? '0 : slot_q;
        w_cyc    = frame_sync ? '0 : cyc_q;

        if (frame_sync) begin
            shadow_d = '0;
            state_d  = COLLECT;
        end

        if (w_active) begin
            if (w_cyc == CYC_W'(SAMPLE_OFS)) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (w_slot == SLOT_W'(k)) begin
                        shadow_d[2*k +: 2] = bus_in;
                    end
                end
            end
            if (w_cyc == CYC_W'(SLOT_CYC - 1)) begin
                cyc_d = '0;
                if (w_slot == SLOT_W'(N_CH - 1)) begin
                    slot_d = '0;
                    if (!frame_sync) begin
                        w_push  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    slot_d = w_slot + SLOT_W'(1);
                end
            end else begin
                cyc_d  = w_cyc + CYC_W'(1);
                slot_d = w_slot;
            end
        end

        busy_d     = (state_d == COLLECT);
        w_pop      = !w_empty && word_ready;
        overflow_d = overflow_q || (w_push && w_full && !w_pop);
    end

`ifdef RO_COLLECT_FRAMECNT_EN
    // Tag carries the count before this frame's increment, so frames number from 0.
    always_comb begin
        fcnt_d     = fcnt_q + (w_push ? FRAME_ID_W'(1) : FRAME_ID_W'(0));
        w_fifo_din = {fcnt_q, shadow_d};
        frame_id   = w_fifo_dout[FW-1:WW];
    end

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    always_comb begin
        w_fifo_din = shadow_d;
    end
`endif

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            cyc_q       <= '0;
            shadow_q    <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cyc_q       <= cyc_d;
            shadow_q    <= shadow_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ro_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_ext   (clk_ext),
        .rstb      (rstb),
        .push      (w_push),
        .push_data (w_fifo_din),
        .pop       (w_pop),
        .pop_data  (w_fifo_dout),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign word_out   = w_fifo_dout[WW-1:0];
    assign word_valid = !w_empty;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ro_collector
//  Purpose  : Directed self-checking bench for ro_collector (8 ch x 16 cyc).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ro_collector;

    logic        clk_ext = 1'b0;
    logic        rstb;
    logic        frame_sync;
    logic [1:0]  bus_in;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        frame_err;
    logic        overflow;
`ifdef RO_COLLECT_FRAMECNT_EN
    logic [7:0]  frame_id;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_ext = ~clk_ext;

    ro_collector #(
        .N_CH       (8),
        .SLOT_CYC   (16),
        .SAMPLE_OFS (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_ext    (clk_ext),
        .rstb       (rstb),
        .frame_sync (frame_sync),
        .bus_in     (bus_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .frame_err  (frame_err),
`ifdef RO_COLLECT_FRAMECNT_EN
        .frame_id   (frame_id),
`endif
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: channel k drives k[1:0]; mode 1: 2'b11 except 2'b01 at cycle 8;
    // mode 2: channel k drives 3-k[1:0].
    function automatic logic [1:0] pat(input int mode, input int t);
        int slot;
        int c;
        slot = (t / 16) % 8;
        c    = t % 16;
        case (mode)
            0:       return 2'(slot % 4);
            1:       return (c == 8) ? 2'b01 : 2'b11;
            default: return 2'(3 - (slot % 4));
        endcase
    endfunction

    task automatic step(input logic s, input logic [1:0] b);
        frame_sync = s;
        bus_in     = b;
        @(posedge clk_ext);
        #1;
    endtask

    // Drives frame cycles t0..t0+n-1; frame_sync accompanies t==0.
    task automatic run(input int mode, input int t0, input int n);
        for (int t = t0; t < t0 + n; t++) begin
            step(t == 0, pat(mode, t));
        end
        frame_sync = 1'b0;
    endtask

    initial begin
        rstb       = 1'b0;
        frame_sync = 1'b0;
        bus_in     = 2'b00;
        word_ready = 1'b0;
        repeat (3) @(posedge clk_ext);
        #1;
        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rstb = 1'b1;
        step(1'b0, 2'b00);

        // Basic frame, ready held high while empty
        word_ready = 1'b1;
        run(0, 0, 1);
        check("f1_busy_T1", 32'(busy), 32'h1);
        run(0, 1, 126);
        check("f1_busy_T127", 32'(busy), 32'h1);
        check("f1_valid_T127", 32'(word_valid), 32'h0);
        run(0, 127, 1);
        check("f1_valid_T128", 32'(word_valid), 32'h1);
        check("f1_word", 32'(word_out), 32'hE4E4);
        check("f1_busy_T128", 32'(busy), 32'h0);
        step(1'b0, 2'b00);
        check("f1_popped", 32'(word_valid), 32'h0);

        // Single-point sampling
        word_ready = 1'b0;
        run(1, 0, 128);
        check("f2_valid", 32'(word_valid), 32'h1);
        check("f2_word", 32'(word_out), 32'h5555);
        word_ready = 1'b1;
        step(1'b0, 2'b00);
        word_ready = 1'b0;
        check("f2_popped", 32'(word_valid), 32'h0);

        // Abort at T50
        run(0, 0, 50);
        run(2, 0, 1);
        check("ab_frame_err", 32'(frame_err), 32'h1);
        check("ab_busy", 32'(busy), 32'h1);
        run(2, 1, 1);
        check("ab_frame_err_off", 32'(frame_err), 32'h0);
        run(2, 2, 76);
        check("ab_no_push_T128", 32'(word_valid), 32'h0);
        run(2, 78, 50);
        check("ab_valid_T178", 32'(word_valid), 32'h1);
        check("ab_word", 32'(word_out), 32'h1B1B);
        word_ready = 1'b1;
        step(1'b0, 2'b00);
        word_ready = 1'b0;
        check("ab_popped", 32'(word_valid), 32'h0);

        // Three frames with no consumer
        run(0, 0, 128);
        check("ov_valid1", 32'(word_valid), 32'h1);
        check("ov_word1", 32'(word_out), 32'hE4E4);
        run(1, 0, 1);
        check("ov_b2b_no_err", 32'(frame_err), 32'h0);
        run(1, 1, 127);
        check("ov_not_yet", 32'(overflow), 32'h0);
        check("ov_hold2", 32'(word_out), 32'hE4E4);
        run(2, 0, 128);
        check("ov_set", 32'(overflow), 32'h1);
        check("ov_hold3", 32'(word_out), 32'hE4E4);
        check("ov_valid3", 32'(word_valid), 32'h1);
        word_ready = 1'b1;
        step(1'b0, 2'b00);
        check("ov_second_word", 32'(word_out), 32'h5555);
        check("ov_second_valid", 32'(word_valid), 32'h1);
        step(1'b0, 2'b00);
        check("ov_drained", 32'(word_valid), 32'h0);
        word_ready = 1'b0;
        check("ov_sticky", 32'(overflow), 32'h1);

        // Reset in mid-frame with a word buffered
        run(0, 0, 128);
        check("rm_buffered", 32'(word_valid), 32'h1);
        run(1, 0, 60);
        rstb = 1'b0;
        #1;
        check("rm_valid", 32'(word_valid), 32'h0);
        check("rm_word", 32'(word_out), 32'h0);
        check("rm_busy", 32'(busy), 32'h0);
        check("rm_overflow", 32'(overflow), 32'h0);
        check("rm_frame_err", 32'(frame_err), 32'h0);
        step(1'b0, 2'b00);
        rstb = 1'b1;
        run(1, 61, 67);
        check("rm_no_push", 32'(word_valid), 32'h0);
        check("rm_idle", 32'(busy), 32'h0);

        // Full FIFO, frame completes in the same cycle as a pop
        run(0, 0, 128);
        run(1, 0, 128);
        run(2, 0, 127);
        word_ready = 1'b1;
        run(2, 127, 1);
        check("fp_no_overflow", 32'(overflow), 32'h0);
        check("fp_valid", 32'(word_valid), 32'h1);
        check("fp_head", 32'(word_out), 32'h5555);
        step(1'b0, 2'b00);
        check("fp_tail", 32'(word_out), 32'h1B1B);
        step(1'b0, 2'b00);
        check("fp_drained", 32'(word_valid), 32'h0);
        word_ready = 1'b0;

`ifdef RO_COLLECT_FRAMECNT_EN
        rstb = 1'b0;
        step(1'b0, 2'b00);
        rstb = 1'b1;
        check("fid_reset", 32'(frame_id), 32'h0);
        word_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            run(0, 0, 128);
            check("fid_seq", 32'(frame_id), 32'(i % 256));
        end
        word_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
